// File: rtl/gpmc_pkg.sv
// Shared types and constants for the GPMC-to-SRAM bridge.
package gpmc_pkg;

    localparam int GPMC_AD_W       = 16;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACT,
        ST_RDREQ,
        ST_RDWAIT,
        ST_RDDRV,
        ST_WRCAP,
        ST_WRREQ
    } gpmc_state_t;

endpackage

// File: rtl/gpmc_sram_arb_if.sv
// GPMC pad, local requester and SRAM port bundle for gpmc_sram_arb.
interface gpmc_sram_arb_if #(
    parameter int AW = 10
);
    import gpmc_pkg::*;

    logic                 GPMC_CSN;
    logic                 GPMC_ADVN;
    logic                 GPMC_OEN;
    logic                 GPMC_WEN;
    logic [GPMC_AD_W-1:0] gpmc_ad_in;
    logic [GPMC_AD_W-1:0] gpmc_ad_out;
    logic                 gpmc_ad_oe;

    logic                 loc_req;
    logic                 loc_we;
    logic [AW-1:0]        loc_addr;
    logic [GPMC_AD_W-1:0] loc_wdata;
    logic                 loc_gnt;
    logic [GPMC_AD_W-1:0] loc_rdata;
    logic                 loc_rvalid;

    logic                 ram_en;
    logic                 ram_we;
    logic [AW-1:0]        ram_addr;
    logic [GPMC_AD_W-1:0] ram_wdata;
    logic [GPMC_AD_W-1:0] ram_rdata;

    modport slave (
        input  GPMC_CSN, GPMC_ADVN, GPMC_OEN, GPMC_WEN, gpmc_ad_in,
        output gpmc_ad_out, gpmc_ad_oe,
        input  loc_req, loc_we, loc_addr, loc_wdata,
        output loc_gnt, loc_rdata, loc_rvalid,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output GPMC_CSN, GPMC_ADVN, GPMC_OEN, GPMC_WEN, gpmc_ad_in,
        input  gpmc_ad_out, gpmc_ad_oe,
        output loc_req, loc_we, loc_addr, loc_wdata,
        input  loc_gnt, loc_rdata, loc_rvalid,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );

endinterface

// File: rtl/gpmc_sync.sv
// Multi-stage synchroniser; strobes and AD share the same depth so they stay aligned.
module gpmc_sync #(
    parameter int           W       = 1,
    parameter int           STAGES  = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [STAGES-1:0][W-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RST_VAL}};
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/gpmc_sram_arb.sv
// GPMC multiplexed-bus slave sequencing a single-port SRAM, shared with a
// lower-priority local requester that takes every cycle GPMC leaves free.
module gpmc_sram_arb
    import gpmc_pkg::*;
#(
    parameter int AW          = 10,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    gpmc_sram_arb_if.slave bus
);

    logic [3:0]           s_strb;
    logic [GPMC_AD_W-1:0] s_ad;
    logic                 s_csn, s_advn, s_oen, s_wen;
    logic                 s_oen_d, s_wen_d;
    logic                 oe_fall, we_rise;

    gpmc_state_t          state, state_n;
    logic [AW-1:0]        addr_q;
    logic [GPMC_AD_W-1:0] data_q;

    logic                 ram_en, ram_we, gnt;
    logic [AW-1:0]        ram_addr;
    logic [GPMC_AD_W-1:0] ram_wdata;
    logic                 rd_pend;
    logic                 ad_oe, rvalid;
    logic [GPMC_AD_W-1:0] ad_out, rdata;

    gpmc_sync #(.W(4), .STAGES(SYNC_STAGES), .RST_VAL(4'hF)) u_sync_strb (
        .clk(CLK),
        .rst(RST),
        .d  ({bus.GPMC_CSN, bus.GPMC_ADVN, bus.GPMC_OEN, bus.GPMC_WEN}),
        .q  (s_strb)
    );

    gpmc_sync #(.W(GPMC_AD_W), .STAGES(SYNC_STAGES), .RST_VAL('0)) u_sync_ad (
        .clk(CLK),
        .rst(RST),
        .d  (bus.gpmc_ad_in),
        .q  (s_ad)
    );

    assign {s_csn, s_advn, s_oen, s_wen} = s_strb;
    assign oe_fall = s_oen_d & ~s_oen;
    assign we_rise = ~s_wen_d & s_wen;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            s_oen_d <= 1'b1;
            s_wen_d <= 1'b1;
        end else begin
            state   <= state_n;
            s_oen_d <= s_oen;
            s_wen_d <= s_wen;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (!s_csn && !s_advn) state_n = ST_ADDR;
            ST_ADDR:   if (s_advn) state_n = ST_ACT;
            ST_ACT: begin
                if (oe_fall)     state_n = ST_RDREQ;
                else if (!s_wen) state_n = ST_WRCAP;
            end
            ST_RDREQ:  state_n = ST_RDWAIT;
            ST_RDWAIT: state_n = ST_RDDRV;
            ST_RDDRV:  if (s_oen) state_n = ST_ACT;
            ST_WRCAP:  if (we_rise) state_n = ST_WRREQ;
            ST_WRREQ:  state_n = ST_ACT;
            default:   state_n = ST_IDLE;
        endcase
        // Chip-select release aborts whatever GPMC op is in flight.
        if (s_csn) state_n = ST_IDLE;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            case (state)
                ST_ADDR:  addr_q <= s_ad[AW-1:0];
                ST_RDDRV: if (s_oen) addr_q <= addr_q + AW'(1);
                ST_WRCAP: data_q <= s_ad;
                ST_WRREQ: addr_q <= addr_q + AW'(1);
                default:  ;
            endcase
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        gnt       = 1'b0;
        if (state == ST_RDREQ) begin
            ram_en   = 1'b1;
            ram_addr = addr_q;
        end else if (state == ST_WRREQ) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = addr_q;
            ram_wdata = data_q;
        end else if (bus.loc_req) begin
            gnt       = 1'b1;
            ram_en    = 1'b1;
            ram_we    = bus.loc_we;
            ram_addr  = bus.loc_addr;
            ram_wdata = bus.loc_wdata;
        end
    end

    // Read data is captured in the cycle the RAM returns it, so rvalid and
    // rdata (like oe and ad_out) present together one cycle later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ad_oe   <= 1'b0;
            ad_out  <= '0;
            rd_pend <= 1'b0;
            rvalid  <= 1'b0;
            rdata   <= '0;
        end else begin
            ad_oe   <= (state_n == ST_RDDRV);
            if (state == ST_RDWAIT) ad_out <= bus.ram_rdata;
            rd_pend <= gnt & ~bus.loc_we;
            rvalid  <= rd_pend;
            if (rd_pend) rdata <= bus.ram_rdata;
        end
    end

    assign bus.ram_en      = ram_en;
    assign bus.ram_we      = ram_we;
    assign bus.ram_addr    = ram_addr;
    assign bus.ram_wdata   = ram_wdata;
    assign bus.loc_gnt     = gnt;
    assign bus.loc_rvalid  = rvalid;
    assign bus.loc_rdata   = rdata;
    assign bus.gpmc_ad_oe  = ad_oe;
    assign bus.gpmc_ad_out = ad_out;

endmodule
